// File: rtl/servant_rst_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : servant_rst_seq_pkg
//  Description : Shared definitions for the servant PLL/reset sequencer.
//                - state_t   : sequencer state encoding (also driven on o_state)
//                - cnt_width : width of the shared down-counter, derived from
//                              the largest timing parameter
//  Revision    : 1.0 - initial release
// ============================================================================
package servant_rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_SOFT      = 3'd4,
        ST_FAIL      = 3'd5
    } state_t;

    localparam int c_RETRY_W = 4;

    // The counter is always loaded with (cycles - 1), so clog2 of the largest
    // cycle count is enough. A single bit is kept as the floor so that all
    // parameters equal to 1 still yield a legal vector.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/servant_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : servant_sync2
//  Description : Two-flop synchroniser for a single asynchronous input.
//                Both flops reset asynchronously to 0.
//  Ports       : i_clk   - destination clock
//                i_rst_n - asynchronous active-low reset
//                i_d     - asynchronous input
//                o_q     - synchronised output (2 cycles of latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module servant_sync2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/servant_rst_seq.sv
`default_nettype none
// ============================================================================
//  Module      : servant_rst_seq
//  Description : PLL and SoC reset sequencer running on the always-on board
//                reference clock. Pulses PLL RESETB, waits for LOCK with a
//                timeout/retry limit, requires LOCK to be stable before
//                releasing the SoC reset, re-sequences on any loss of lock and
//                supports a software-requested SoC-only reset.
//  Ports       : i_clk        - board reference clock
//                i_rst_n      - asynchronous active-low reset
//                i_lock       - PLL LOCK (asynchronous to i_clk)
//                i_soft_rst   - single-cycle SoC-only reset request
//                i_retry      - single-cycle request to leave FAIL
//                o_pll_resetb - PLL RESETB (0 holds the PLL in reset)
//                o_rst        - active-high SoC reset (i_clk domain)
//                o_state      - current state encoding
//                o_retries    - failed lock attempts since last RUN entry
//                o_fail       - high while in FAIL
//  Revision    : 1.0 - initial release
// ============================================================================
module servant_rst_seq
    import servant_rst_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES  = 16,
    parameter int LOCK_TIMEOUT    = 4096,
    parameter int LOCK_STABLE     = 256,
    parameter int SOFT_RST_CYCLES = 16,
    parameter int MAX_RETRIES     = 3
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_lock,
    input  logic       i_soft_rst,
    input  logic       i_retry,
    output logic       o_pll_resetb,
    output logic       o_rst,
    output logic [2:0] o_state,
    output logic [3:0] o_retries,
    output logic       o_fail
);

    localparam int c_CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE, SOFT_RST_CYCLES);

    localparam logic [c_CW-1:0]      c_LD_PLL    = c_CW'(PLL_RST_CYCLES - 1);
    localparam logic [c_CW-1:0]      c_LD_WAIT   = c_CW'(LOCK_TIMEOUT - 1);
    localparam logic [c_CW-1:0]      c_LD_STABLE = c_CW'(LOCK_STABLE - 1);
    localparam logic [c_CW-1:0]      c_LD_SOFT   = c_CW'(SOFT_RST_CYCLES - 1);
    localparam logic [c_CW-1:0]      c_ONE       = c_CW'(1);
    localparam logic [c_RETRY_W-1:0] c_MAX_R     = c_RETRY_W'(MAX_RETRIES);
    localparam logic [c_RETRY_W-1:0] c_R_SAT     = '1;

    // ------------------------------------------------------------------------
    // Lock synchroniser: every decision below uses w_lock_s only.
    // ------------------------------------------------------------------------
    logic w_lock_s;

    servant_sync2 u_lock_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_lock),
        .o_q     (w_lock_s)
    );

    // ------------------------------------------------------------------------
    // State, shared counter and registered outputs
    // ------------------------------------------------------------------------
    state_t                 r_state;
    logic [c_CW-1:0]        r_cnt;
    logic [c_RETRY_W-1:0]   r_retries;
    logic                   r_pll_resetb;
    logic                   r_rst;
    logic                   r_fail;

    state_t                 w_next;
    logic [c_RETRY_W-1:0]   w_retries_next;
    logic [c_RETRY_W-1:0]   w_retry_inc;
    logic                   w_cnt_zero;

    // Counter reload value for the state being entered. RUN and FAIL are not
    // timed; they load zero.
    function automatic logic [c_CW-1:0] load_for(input state_t s);
        case (s)
            ST_PLL_RST:   return c_LD_PLL;
            ST_WAIT_LOCK: return c_LD_WAIT;
            ST_STABLE:    return c_LD_STABLE;
            ST_SOFT:      return c_LD_SOFT;
            default:      return '0;
        endcase
    endfunction

    assign w_cnt_zero  = (r_cnt == '0);
    // Saturating increment so the retry count never wraps.
    assign w_retry_inc = (r_retries == c_R_SAT) ? r_retries : r_retries + c_RETRY_W'(1);

    always_comb begin
        w_next         = r_state;
        w_retries_next = r_retries;
        case (r_state)
            ST_PLL_RST: begin
                if (w_cnt_zero) begin
                    w_next = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_next = ST_STABLE;
                end else if (w_cnt_zero) begin
                    w_retries_next = w_retry_inc;
                    w_next         = (w_retry_inc == c_MAX_R) ? ST_FAIL : ST_PLL_RST;
                end
            end
            ST_STABLE: begin
                // A single low cycle restarts the whole wait; retries kept.
                if (!w_lock_s) begin
                    w_next = ST_WAIT_LOCK;
                end else if (w_cnt_zero) begin
                    w_next         = ST_RUN;
                    w_retries_next = '0;
                end
            end
            ST_RUN: begin
                if (!w_lock_s) begin
                    w_next = ST_PLL_RST;
                end else if (i_soft_rst) begin
                    w_next = ST_SOFT;
                end
            end
            ST_SOFT: begin
                // Lock loss outranks the soft-reset timer expiring.
                if (!w_lock_s) begin
                    w_next = ST_PLL_RST;
                end else if (w_cnt_zero) begin
                    w_next = ST_RUN;
                end
            end
            ST_FAIL: begin
                if (i_retry) begin
                    w_next         = ST_PLL_RST;
                    w_retries_next = '0;
                end
            end
            default: begin
                w_next = ST_PLL_RST;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as r_state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_PLL_RST;
            r_cnt        <= c_LD_PLL;
            r_retries    <= '0;
            r_pll_resetb <= 1'b0;
            r_rst        <= 1'b1;
            r_fail       <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_retries <= w_retries_next;
            if (w_next != r_state) begin
                r_cnt <= load_for(w_next);
            end else if (!w_cnt_zero) begin
                r_cnt <= r_cnt - c_ONE;
            end
            r_pll_resetb <= (w_next != ST_PLL_RST) && (w_next != ST_FAIL);
            r_rst        <= (w_next != ST_RUN);
            r_fail       <= (w_next == ST_FAIL);
        end
    end

    assign o_pll_resetb = r_pll_resetb;
    assign o_rst        = r_rst;
    assign o_fail       = r_fail;
    assign o_state      = r_state;
    assign o_retries    = r_retries;

endmodule
`default_nettype wire

// File: tb/tb_servant_rst_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_servant_rst_seq
//  Description : Self-checking bench for servant_rst_seq. Expected output
//                vectors {pll_resetb, rst, fail, state, retries} are queued
//                with the cycle they are due in and compared on the falling
//                edge of that cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_servant_rst_seq;
    import servant_rst_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       lock;
    logic       soft_rst;
    logic       retry;
    logic       o_pll_resetb;
    logic       o_rst;
    logic [2:0] o_state;
    logic [3:0] o_retries;
    logic       o_fail;

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;

    int         sb_at[$];
    logic [9:0] sb_exp[$];
    string      sb_tag[$];

    logic [9:0] w_obs;
    assign w_obs = {o_pll_resetb, o_rst, o_fail, o_state, o_retries};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    servant_rst_seq #(
        .PLL_RST_CYCLES  (4),
        .LOCK_TIMEOUT    (8),
        .LOCK_STABLE     (5),
        .SOFT_RST_CYCLES (3),
        .MAX_RETRIES     (2)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_lock       (lock),
        .i_soft_rst   (soft_rst),
        .i_retry      (retry),
        .o_pll_resetb (o_pll_resetb),
        .o_rst        (o_rst),
        .o_state      (o_state),
        .o_retries    (o_retries),
        .o_fail       (o_fail)
    );

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got pllb/rst/fail/state/retries=%b/%b/%b/%0d/%0d, expected %b/%b/%b/%0d/%0d",
                     tag, cyc, obs[9], obs[8], obs[7], obs[6:4], obs[3:0],
                     exp[9], exp[8], exp[7], exp[6:4], exp[3:0]);
        end
    endtask

    // Output table per state, straight from the state descriptions.
    function automatic logic [9:0] exp_of(input logic [2:0] st, input logic [3:0] ret);
        logic pllb, rst, fail;
        case (st)
            3'd0:    begin pllb = 1'b0; rst = 1'b1; fail = 1'b0; end
            3'd1:    begin pllb = 1'b1; rst = 1'b1; fail = 1'b0; end
            3'd2:    begin pllb = 1'b1; rst = 1'b1; fail = 1'b0; end
            3'd3:    begin pllb = 1'b1; rst = 1'b0; fail = 1'b0; end
            3'd4:    begin pllb = 1'b1; rst = 1'b1; fail = 1'b0; end
            default: begin pllb = 1'b0; rst = 1'b1; fail = 1'b1; end
        endcase
        return {pllb, rst, fail, st, ret};
    endfunction

    // Queue n consecutive expectations starting dc cycles from now.
    task automatic push_seg(input int dc, input int n, input logic [2:0] st,
                            input logic [3:0] ret, input string tag);
        for (int i = 0; i < n; i++) begin
            sb_at.push_back(cyc + dc + i);
            sb_exp.push_back(exp_of(st, ret));
            sb_tag.push_back(tag);
        end
    endtask

    // Advance to just after the posedge that makes cyc == c.
    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        while (sb_at.size() > 0 && sb_at[0] == cyc) begin
            chk(sb_tag[0], w_obs, sb_exp[0]);
            void'(sb_at.pop_front());
            void'(sb_exp.pop_front());
            void'(sb_tag.pop_front());
        end
    end

    initial begin
        int b;
        rst_n    = 1'b0;
        lock     = 1'b0;
        soft_rst = 1'b0;
        retry    = 1'b0;

        // Reset state
        goto(2);
        push_seg(0, 1, ST_PLL_RST, 4'd0, "reset_vals");

        // Normal boot: release, lock rises after cycle 6, run 8 cycles later
        goto(3);
        b = cyc;
        rst_n = 1'b1;
        push_seg(0,  4, ST_PLL_RST,   4'd0, "boot_rstb");
        push_seg(4,  5, ST_WAIT_LOCK, 4'd0, "boot_wait");
        push_seg(9,  5, ST_STABLE,    4'd0, "boot_stable");
        push_seg(14, 2, ST_RUN,       4'd0, "boot_run");
        goto(b + 6);
        lock = 1'b1;
        goto(b + 16);

        // Soft reset in RUN; a retry pulse in RUN must be ignored
        b = cyc;
        soft_rst = 1'b1;
        push_seg(0, 1, ST_RUN,  4'd0, "soft_pre");
        push_seg(1, 3, ST_SOFT, 4'd0, "soft_hold");
        push_seg(4, 4, ST_RUN,  4'd0, "soft_post");
        goto(b + 1);
        soft_rst = 1'b0;
        goto(b + 5);
        retry = 1'b1;
        goto(b + 6);
        retry = 1'b0;
        goto(b + 8);

        // Lock loss during SOFT (coincides with timer expiry), then timeouts to FAIL
        b = cyc;
        soft_rst = 1'b1;
        push_seg(0,  1, ST_RUN,       4'd0, "sl_pre");
        push_seg(1,  3, ST_SOFT,      4'd0, "sl_soft");
        push_seg(4,  4, ST_PLL_RST,   4'd0, "sl_pllrst");
        push_seg(8,  8, ST_WAIT_LOCK, 4'd0, "to_wait0");
        push_seg(16, 4, ST_PLL_RST,   4'd1, "to_pllrst1");
        push_seg(20, 8, ST_WAIT_LOCK, 4'd1, "to_wait1");
        push_seg(28, 6, ST_FAIL,      4'd2, "fail_hold");
        goto(b + 1);
        soft_rst = 1'b0;
        lock     = 1'b0;
        goto(b + 30);
        soft_rst = 1'b1;   // ignored outside RUN
        goto(b + 31);
        soft_rst = 1'b0;
        goto(b + 34);

        // Retry out of FAIL, then a one-cycle lock glitch during STABLE
        b = cyc;
        retry = 1'b1;
        push_seg(0,  1, ST_FAIL,      4'd2, "fail_pre");
        push_seg(1,  4, ST_PLL_RST,   4'd0, "retry_pll");
        push_seg(5,  3, ST_WAIT_LOCK, 4'd0, "gl_wait");
        push_seg(8,  4, ST_STABLE,    4'd0, "gl_stable_a");
        push_seg(12, 1, ST_WAIT_LOCK, 4'd0, "gl_rewait");
        push_seg(13, 5, ST_STABLE,    4'd0, "gl_stable_b");
        push_seg(18, 2, ST_RUN,       4'd0, "gl_run");
        goto(b + 1);
        retry = 1'b0;
        goto(b + 5);
        lock = 1'b1;
        goto(b + 9);
        lock = 1'b0;
        goto(b + 10);
        lock = 1'b1;
        goto(b + 20);

        // Lock loss in RUN, relock, then async reset in the middle of STABLE
        b = cyc;
        lock = 1'b0;
        push_seg(0,  3, ST_RUN,       4'd0, "ll_run");
        push_seg(3,  4, ST_PLL_RST,   4'd0, "ll_pllrst");
        push_seg(7,  3, ST_WAIT_LOCK, 4'd0, "ll_wait");
        push_seg(10, 2, ST_STABLE,    4'd0, "ar_stable");
        push_seg(12, 2, ST_PLL_RST,   4'd0, "ar_reset");
        goto(b + 7);
        lock = 1'b1;
        goto(b + 12);
        rst_n = 1'b0;
        #1;
        chk("async_now", w_obs, exp_of(ST_PLL_RST, 4'd0));
        goto(b + 14);
        rst_n = 1'b1;
        push_seg(0, 4, ST_PLL_RST,   4'd0, "rel_pll");
        push_seg(4, 1, ST_WAIT_LOCK, 4'd0, "rel_wait");
        goto(b + 20);

        chk("sb_drain", 10'(sb_at.size()), 10'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
